cheat_code_loader: RTL and testbench

//  Upstream feeder of the cheat engine: assembles 16-bit ioctl download words into 128-bit cheat records.

---
 rtl/cheat_pkg.sv | 31 +++
 rtl/cheat_code_loader_if.sv | 28 ++
 rtl/cheat_code_loader.sv | 114 +++++++++++
 tb/tb_cheat_code_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cheat_pkg.sv
// Shared constants and types for the cheat loader and the cheat engine code bus.
package cheat_pkg;

  localparam int unsigned CODE_WIDTH      = 129;
  localparam int unsigned WORD_WIDTH      = 16;
  localparam int unsigned RECORD_WIDTH    = CODE_WIDTH - 1;
  localparam int unsigned RECORD_WORDS    = RECORD_WIDTH / WORD_WIDTH;
  localparam int unsigned IDX_WIDTH       = $clog2(RECORD_WORDS);
  localparam int unsigned ADDR_WIDTH      = 25;
  localparam int unsigned INDEX_WIDTH     = 8;
  localparam int unsigned MAX_CODES       = 16;
  localparam int unsigned COUNT_WIDTH     = $clog2(MAX_CODES + 1);
  localparam int unsigned CODE_STROBE_BIT = CODE_WIDTH - 1;

  localparam logic [INDEX_WIDTH-1:0] CHEAT_INDEX = 8'h04;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    COLLECT
  } loader_state_t;

  // Record field layout on code[RECORD_WIDTH-1:0] as consumed by the cheat engine.
  typedef struct packed {
    logic [31:0] flags;  // [127:96]
    logic [31:0] addr;   // [95:64]
    logic [31:0] comp;   // [63:32]
    logic [31:0] data;   // [31:0]
  } cheat_record_t;

endpackage

// File: rtl/cheat_code_loader_if.sv
// ioctl download port plus the code bus towards the cheat engine.
interface cheat_code_loader_if;
  import cheat_pkg::*;

  logic                    ioctl_download;
  logic [INDEX_WIDTH-1:0]  ioctl_index;
  logic                    ioctl_wr;
  logic [ADDR_WIDTH-1:0]   ioctl_addr;
  logic [WORD_WIDTH-1:0]   ioctl_dout;
  logic                    ioctl_wait;
  logic [CODE_WIDTH-1:0]   code;
  logic                    gg_reset;
  logic [COUNT_WIDTH-1:0]  code_count;
  logic                    overflow;

  // Host side: drives the download, observes the loader outputs.
  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_wait, code, gg_reset, code_count, overflow
  );

  // Loader side.
  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_wait, code, gg_reset, code_count, overflow
  );

endinterface

// File: rtl/cheat_code_loader.sv
// Assembles 16-bit ioctl words into 128-bit cheat records and strobes them to the engine.
// Optional feature: CHEAT_LOADER_LIMIT_EN drops records beyond MAX_CODES and flags overflow.
module cheat_code_loader
  import cheat_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  cheat_code_loader_if.slave bus
);

  loader_state_t           r_state;
  logic                    r_prev_sel;
  logic [RECORD_WORDS-1:0] r_mask;
  logic [RECORD_WIDTH-1:0] r_buf;
  logic [CODE_WIDTH-1:0]   r_code;
  logic                    r_gg_reset;
  logic                    r_wait;
  logic [COUNT_WIDTH-1:0]  r_count;
  logic                    r_overflow;

  logic                    w_sel;
  logic                    w_start;
  logic                    w_wr;
  logic [IDX_WIDTH-1:0]    w_idx;
  logic [RECORD_WORDS-1:0] w_mask_next;
  logic [RECORD_WIDTH-1:0] w_buf_next;
  logic                    w_unused_addr;

  assign w_sel   = bus.ioctl_download && (bus.ioctl_index == CHEAT_INDEX);
  assign w_start = w_sel && !r_prev_sel;
  assign w_wr    = bus.ioctl_wr && w_sel && (r_state == COLLECT);
  assign w_idx   = bus.ioctl_addr[IDX_WIDTH:1];

  // Byte-lane bit and upper address bits carry no record information.
  assign w_unused_addr = ^{bus.ioctl_addr[ADDR_WIDTH-1:IDX_WIDTH+1], bus.ioctl_addr[0]};

  // Buffer and mask as they will look after the current write lands.
  always_comb begin
    w_mask_next = r_mask;
    w_buf_next  = r_buf;
    if (w_wr) begin
      w_mask_next[w_idx] = 1'b1;
      w_buf_next[32'(w_idx) * WORD_WIDTH +: WORD_WIDTH] = bus.ioctl_dout;
    end
  end

  // Loader FSM with registered outputs; a completed record commits on the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_prev_sel <= 1'b0;
      r_mask     <= '0;
      r_buf      <= '0;
      r_code     <= '0;
      r_gg_reset <= 1'b0;
      r_wait     <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_prev_sel              <= w_sel;
      r_gg_reset              <= 1'b0;
      r_wait                  <= 1'b0;
      r_code[CODE_STROBE_BIT] <= 1'b0;
      if (w_start) begin
        r_state    <= CLEAR;
        r_gg_reset <= 1'b1;
        r_wait     <= 1'b1;
        r_count    <= '0;
        r_overflow <= 1'b0;
        r_mask     <= '0;
        r_buf      <= '0;
      end else begin
        case (r_state)
          IDLE:  r_state <= IDLE;
          CLEAR: r_state <= COLLECT;
          COLLECT: begin
            if (!w_sel) begin
              r_state <= IDLE;
              r_mask  <= '0;
            end else if (w_wr) begin
              r_buf <= w_buf_next;
              if (&w_mask_next) begin
                r_mask <= '0;
`ifdef CHEAT_LOADER_LIMIT_EN
                if (r_count == COUNT_WIDTH'(MAX_CODES)) begin
                  r_overflow <= 1'b1;
                end else begin
                  r_code  <= {1'b1, w_buf_next};
                  r_count <= r_count + COUNT_WIDTH'(1);
                end
`else
                r_code <= {1'b1, w_buf_next};
                if (r_count != COUNT_WIDTH'(MAX_CODES)) begin
                  r_count <= r_count + COUNT_WIDTH'(1);
                end
`endif
              end else begin
                r_mask <= w_mask_next;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.code       = r_code;
  assign bus.gg_reset   = r_gg_reset;
  assign bus.ioctl_wait = r_wait;
  assign bus.code_count = r_count;
  assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_cheat_code_loader.sv
// Randomized self-checking bench for cheat_code_loader against a record-level model.
module tb_cheat_code_loader;
  import cheat_pkg::*;

  localparam int unsigned CW = CODE_WIDTH;
  typedef logic [RECORD_WIDTH-1:0] rec_t;

  logic clk;
  logic reset;

  cheat_code_loader_if bus_if ();

  cheat_code_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: words seen in the current record, expected strobes, counters.
  logic [WORD_WIDTH-1:0] m_word [RECORD_WORDS];
  bit                    m_have [RECORD_WORDS];
  rec_t                  exp_q  [$];
  int                    m_count;
  bit                    m_ovf;
  int                    m_pushed;
  int                    m_gg_exp;
  int                    strobes_seen;
  int                    gg_seen;
  rec_t                  m_hold;
  bit                    m_hold_chk;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_clear_words();
    foreach (m_have[i]) m_have[i] = 1'b0;
  endfunction

  function automatic void model_start();
    model_clear_words();
    m_count = 0;
    m_ovf   = 1'b0;
    m_gg_exp++;
  endfunction

  function automatic void model_write(input int k, input logic [WORD_WIDTH-1:0] d);
    rec_t rec;
    bit   full;
    m_word[k] = d;
    m_have[k] = 1'b1;
    full = 1'b1;
    foreach (m_have[i]) if (!m_have[i]) full = 1'b0;
    if (!full) return;
    rec = '0;
    foreach (m_word[i]) rec = rec | (rec_t'(m_word[i]) << (WORD_WIDTH * i));
    model_clear_words();
`ifdef CHEAT_LOADER_LIMIT_EN
    if (m_count == MAX_CODES) begin
      m_ovf = 1'b1;
    end else begin
      exp_q.push_back(rec);
      m_pushed++;
      m_count++;
    end
`else
    exp_q.push_back(rec);
    m_pushed++;
    if (m_count < MAX_CODES) m_count++;
`endif
  endfunction

  // Output monitor: every strobe must match the oldest expected record, then hold.
  always @(negedge clk) begin
    if (bus_if.gg_reset === 1'b1) gg_seen++;
    if (bus_if.code[CODE_STROBE_BIT] === 1'b1) begin
      strobes_seen++;
      check("strobe_expected", CW'(exp_q.size() != 0), CW'(1));
      if (exp_q.size() != 0) begin
        m_hold     = exp_q.pop_front();
        m_hold_chk = 1'b1;
        check("record", CW'(bus_if.code[RECORD_WIDTH-1:0]), CW'(m_hold));
      end
    end else if (m_hold_chk) begin
      m_hold_chk = 1'b0;
      check("record_hold", CW'(bus_if.code[RECORD_WIDTH-1:0]), CW'(m_hold));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 8 && bus_if.ioctl_wait !== 1'b0; i++) tick();
    check("wait_release", CW'(bus_if.ioctl_wait), CW'(0));
  endtask

  // Expects the CLEAR cycle one edge after the selection rises.
  task automatic expect_clear();
    model_start();
    tick();
    check("gg_reset", CW'(bus_if.gg_reset), CW'(1));
    check("wait_in_clear", CW'(bus_if.ioctl_wait), CW'(1));
    check("count_cleared", CW'(bus_if.code_count), CW'(0));
    check("ovf_cleared", CW'(bus_if.overflow), CW'(0));
    wait_ready();
  endtask

  task automatic start_dl();
    bus_if.ioctl_index    = CHEAT_INDEX;
    bus_if.ioctl_download = 1'b1;
    expect_clear();
  endtask

  task automatic wr(input int k, input logic [WORD_WIDTH-1:0] d, input bit counted);
    logic [ADDR_WIDTH-1:0] a;
    a = ADDR_WIDTH'($urandom);
    a[IDX_WIDTH:1] = IDX_WIDTH'(k);
    bus_if.ioctl_wr   = 1'b1;
    bus_if.ioctl_addr = a;
    bus_if.ioctl_dout = d;
    if (counted) model_write(k, d);
    tick();
    bus_if.ioctl_wr = 1'b0;
  endtask

  task automatic send_record(input bit gaps);
    int perm [RECORD_WORDS];
    foreach (perm[i]) perm[i] = i;
    for (int i = RECORD_WORDS - 1; i > 0; i--) begin
      int j;
      int t;
      j = int'($urandom_range(i, 0));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    foreach (perm[i]) begin
      wr(perm[i], WORD_WIDTH'($urandom), 1'b1);
      if (gaps) repeat ($urandom_range(2, 0)) tick();
    end
  endtask

  task automatic end_dl(input string tag);
    bus_if.ioctl_download = 1'b0;
    model_clear_words();
    tick();
    tick();
    check({tag, "_pending"}, CW'(exp_q.size()), CW'(0));
    check({tag, "_strobes"}, CW'(strobes_seen), CW'(m_pushed));
    check({tag, "_gg_count"}, CW'(gg_seen), CW'(m_gg_exp));
    check({tag, "_code_count"}, CW'(bus_if.code_count), CW'(m_count));
    check({tag, "_overflow"}, CW'(bus_if.overflow), CW'(m_ovf));
  endtask

  initial begin
    int order [RECORD_WORDS];
    m_count = 0; m_ovf = 1'b0; m_pushed = 0; m_gg_exp = 0;
    strobes_seen = 0; gg_seen = 0; m_hold = '0; m_hold_chk = 1'b0;
    model_clear_words();
    reset                 = 1'b1;
    bus_if.ioctl_download = 1'b0;
    bus_if.ioctl_index    = '0;
    bus_if.ioctl_wr       = 1'b0;
    bus_if.ioctl_addr     = '0;
    bus_if.ioctl_dout     = '0;
    repeat (3) tick();
    check("rst_code", bus_if.code, CW'(0));
    check("rst_gg", CW'(bus_if.gg_reset), CW'(0));
    check("rst_wait", CW'(bus_if.ioctl_wait), CW'(0));
    check("rst_count", CW'(bus_if.code_count), CW'(0));
    check("rst_ovf", CW'(bus_if.overflow), CW'(0));
    reset = 1'b0;
    tick();

    // In-order words with data 0x1111*k.
    start_dl();
    for (int k = 0; k < int'(RECORD_WORDS); k++) wr(k, WORD_WIDTH'(32'h1111 * k), 1'b1);
    end_dl("t1");

    // Scrambled order yields the same record.
    order = '{7, 3, 0, 1, 2, 4, 6, 5};
    start_dl();
    foreach (order[i]) wr(order[i], WORD_WIDTH'(32'h1111 * order[i]), 1'b1);
    end_dl("t2");

    // Repeated word index: the later write wins.
    start_dl();
    wr(2, 16'hAAAA, 1'b1);
    wr(2, 16'hBBBB, 1'b1);
    for (int k = 0; k < int'(RECORD_WORDS); k++) if (k != 2) wr(k, WORD_WIDTH'($urandom), 1'b1);
    end_dl("t3");

    // Partial record discarded when the download drops.
    start_dl();
    for (int k = 0; k < 5; k++) wr(k, WORD_WIDTH'($urandom), 1'b1);
    end_dl("t4a");
    start_dl();
    send_record(1'b0);
    end_dl("t4b");

    // Capacity: 17 back-to-back records.
    start_dl();
    for (int r = 0; r < 17; r++) send_record(1'b0);
    end_dl("t5");

    // Foreign index writes are ignored, then reset mid-record with download held.
    bus_if.ioctl_download = 1'b1;
    bus_if.ioctl_index    = 8'h00;
    tick();
    for (int k = 0; k < int'(RECORD_WORDS); k++) wr(k, WORD_WIDTH'($urandom), 1'b0);
    tick();
    check("idx0_gg", CW'(gg_seen), CW'(m_gg_exp));
    check("idx0_strobes", CW'(strobes_seen), CW'(m_pushed));
    start_dl();
    send_record(1'b0);
    for (int k = 0; k < 3; k++) wr(k, WORD_WIDTH'($urandom), 1'b1);
    reset = 1'b1;
    model_clear_words();
    m_count = 0;
    m_ovf   = 1'b0;
    tick();
    tick();
    check("t6_code", bus_if.code, CW'(0));
    check("t6_gg", CW'(bus_if.gg_reset), CW'(0));
    check("t6_wait", CW'(bus_if.ioctl_wait), CW'(0));
    check("t6_count", CW'(bus_if.code_count), CW'(0));
    check("t6_ovf", CW'(bus_if.overflow), CW'(0));
    reset = 1'b0;
    expect_clear();
    send_record(1'b1);
    end_dl("t6");

    // Random downloads with gaps between writes.
    for (int d = 0; d < 4; d++) begin
      start_dl();
      repeat ($urandom_range(4, 1)) send_record(1'b1);
      for (int k = 0; k < int'($urandom_range(7, 0)); k++) wr(k, WORD_WIDTH'($urandom), 1'b1);
      end_dl("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
